// File: rtl/adc_sample_buffer_if.sv
// ============================================================================
// Module  : adc_sample_buffer_if
// Purpose : Bundles the deserialiser inputs, pop request and FIFO status
//           outputs of adc_sample_buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_sample_buffer_if #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16
);
    localparam int c_LW = $clog2(DEPTH) + 1;

    logic              sdi;
    logic              reading;
    logic              write_en;
    logic              rd_en;
    logic              clr_flags;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [c_LW-1:0]   level;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              frame_err;

    modport master (
        output sdi, reading, write_en, rd_en, clr_flags,
        input  rd_data, rd_valid, level, empty, full, overflow, frame_err
    );

    modport slave (
        input  sdi, reading, write_en, rd_en, clr_flags,
        output rd_data, rd_valid, level, empty, full, overflow, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/adc_sample_buffer.sv
// ============================================================================
// Module  : adc_sample_buffer
// Purpose : Deserialises ADC DOUT frames and stores them in an overwriting
//           circular FIFO drained through a registered pop port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16
) (
    input  wire               sck,
    input  wire               reset,
    adc_sample_buffer_if.slave bus_if
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_BW = $clog2(DATA_W + 2);
    localparam logic [c_BW-1:0] c_BC_FULL = c_BW'(DATA_W);
    localparam logic [c_BW-1:0] c_BC_SAT  = c_BW'(DATA_W + 1);
    localparam logic [c_LW-1:0] c_LVL_MAX = c_LW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] sr_q,        sr_d;
    logic [c_BW-1:0]   bitcnt_q,    bitcnt_d;
    logic [c_LW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [c_LW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [c_LW-1:0]   level_q,     level_d;
    logic              empty_q,     empty_d;
    logic              full_q,      full_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              overflow_q,  overflow_d;
    logic              frame_err_q, frame_err_d;

    logic w_ptr_empty;
    logic w_ptr_full;
    logic w_push;
    logic w_bad_commit;
    logic w_pop;
    logic w_overwrite;

    always_comb begin
        w_ptr_empty  = (wr_ptr_q == rd_ptr_q);
        w_ptr_full   = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                       (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
        w_push       = bus_if.write_en && (bitcnt_q == c_BC_FULL);
        w_bad_commit = bus_if.write_en && (bitcnt_q != c_BC_FULL);
        // No bypass: a pop at level 0 is ignored even with a same-cycle push.
        w_pop        = bus_if.rd_en && !w_ptr_empty;
        w_overwrite  = w_push && w_ptr_full && !w_pop;

        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = w_pop;

        if (bus_if.reading) begin
            sr_d = {sr_q[DATA_W-2:0], bus_if.sdi};
        end
        if (bus_if.write_en) begin
            bitcnt_d = '0;
        end else if (bus_if.reading && (bitcnt_q != c_BC_SAT)) begin
            bitcnt_d = bitcnt_q + 1'b1;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // An overwrite drops the oldest entry, so the read side advances too.
        if (w_pop || w_overwrite) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_data_d = mem_q[rd_ptr_q[c_AW-1:0]];
        end

        level_d     = wr_ptr_d - rd_ptr_d;
        empty_d     = (level_d == '0);
        full_d      = (level_d == c_LVL_MAX);
        overflow_d  = w_overwrite  | (overflow_q  & ~bus_if.clr_flags);
        frame_err_d = w_bad_commit | (frame_err_q & ~bus_if.clr_flags);
    end

    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            sr_q        <= '0;
            bitcnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge sck) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= sr_q;
        end
    end

    assign bus_if.rd_data   = rd_data_q;
    assign bus_if.rd_valid  = rd_valid_q;
    assign bus_if.level     = level_q;
    assign bus_if.empty     = empty_q;
    assign bus_if.full      = full_q;
    assign bus_if.overflow  = overflow_q;
    assign bus_if.frame_err = frame_err_q;

endmodule

`default_nettype wire
